// File: rtl/link_power_pair_sequencer.sv
// link_power_pair_sequencer
//   Powers up a set of twisted pairs one at a time once their presence
//   signatures have been debounced, holds the link up while powered pairs
//   remain present, and backs off into a timed retry on any overcurrent.
//
// Ports
//   clk_i             sole clock, rising edge
//   rst_ni            asynchronous active-low reset
//   enable_i          global link-power enable
//   swap_mode_i       crossover request, sampled only when leaving DETECT
//   pair_sense_i      raw asynchronous per-pair presence signatures
//   pair_fault_i      per-pair overcurrent flags
//   pair_power_on_o   per-pair supply enables
//   pair_route_sel_o  per-pair crossover select (1 = swapped)
//   fault_latched_o   sticky per-pair fault record
//   link_up_o         high only in UP
//   state_o           IDLE=0 DETECT=1 RAMP=2 UP=3 FAULT=4
//
// PAIRS must be even and at least 2.
module link_power_pair_sequencer #(
  parameter int PAIRS    = 4,
  parameter int DEBOUNCE = 16,
  parameter int STAGGER  = 64,
  parameter int RETRY    = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             swap_mode_i,
  input  logic [PAIRS-1:0] pair_sense_i,
  input  logic [PAIRS-1:0] pair_fault_i,
  output logic [PAIRS-1:0] pair_power_on_o,
  output logic [PAIRS-1:0] pair_route_sel_o,
  output logic [PAIRS-1:0] fault_latched_o,
  output logic             link_up_o,
  output logic [2:0]       state_o
);

  localparam int DB_W   = $clog2(DEBOUNCE) + 1;
  localparam int ST_W   = $clog2(STAGGER) + 1;
  localparam int RT_W   = $clog2(RETRY) + 1;
  localparam int STEP_W = $clog2(PAIRS) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DETECT = 3'd1,
    S_RAMP   = 3'd2,
    S_UP     = 3'd3,
    S_FAULT  = 3'd4
  } state_e;

  // Two-flop synchronizer on the raw presence signatures.
  logic [PAIRS-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pair_sense_i;
      sync2_q <= sync1_q;
    end
  end

  // Per-pair debounce: the count only runs while the synced sample
  // disagrees with the current debounced value, so any agreeing sample
  // restarts the window.
  logic [PAIRS-1:0] present;

  genvar gi;
  generate
    for (gi = 0; gi < PAIRS; gi++) begin : g_pair
      logic [DB_W-1:0] db_cnt_q, db_cnt_d;
      logic            present_q, present_d;

      always_comb begin
        db_cnt_d  = '0;
        present_d = present_q;
        if (sync2_q[gi] != present_q) begin
          if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
            present_d = ~present_q;
          end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
          end
        end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          db_cnt_q  <= '0;
          present_q <= 1'b0;
        end else begin
          db_cnt_q  <= db_cnt_d;
          present_q <= present_d;
        end
      end

      assign present[gi] = present_q;
    end
  endgenerate

  state_e            state_q, state_d;
  logic [PAIRS-1:0]  power_q, power_d;
  logic [PAIRS-1:0]  route_q, route_d;
  logic [PAIRS-1:0]  fault_q, fault_d;
  logic [PAIRS-1:0]  mask_q, mask_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [ST_W-1:0]   dwell_q, dwell_d;
  logic [RT_W-1:0]   retry_q, retry_d;

  logic [PAIRS-1:0]  hit;
  logic [STEP_W-1:0] step_next;
  logic [PAIRS-1:0]  next_sel;

  assign hit       = pair_fault_i & power_q;
  assign step_next = step_q + STEP_W'(1);
  assign next_sel  = {{(PAIRS-1){1'b0}}, 1'b1} << step_next;

  always_comb begin
    state_d = state_q;
    power_d = power_q;
    route_d = route_q;
    fault_d = fault_q;
    mask_d  = mask_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    retry_d = retry_q;

    if (!enable_i) begin
      // Disable wins over any fault or presence event this cycle.
      state_d = S_IDLE;
      power_d = '0;
      step_d  = '0;
      dwell_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          power_d = '0;
          state_d = S_DETECT;
        end

        S_DETECT: begin
          power_d = '0;
          if (|present) begin
            mask_d  = present;
            route_d = {PAIRS{swap_mode_i}};
            fault_d = '0;
            step_d  = '0;
            // Step 0 begins on this very edge.
            power_d = {{(PAIRS-1){1'b0}}, present[0]};
            dwell_d = present[0] ? ST_W'(STAGGER - 1) : '0;
            state_d = S_RAMP;
          end
        end

        S_RAMP: begin
          if (|hit) begin
            power_d = '0;
            fault_d = fault_q | hit;
            retry_d = RT_W'(RETRY);
            state_d = S_FAULT;
          end else if (dwell_q != '0) begin
            dwell_d = dwell_q - ST_W'(1);
          end else if (step_q == STEP_W'(PAIRS - 1)) begin
            state_d = S_UP;
          end else begin
            step_d  = step_next;
            power_d = power_q | (mask_q & next_sel);
            dwell_d = (|(mask_q & next_sel)) ? ST_W'(STAGGER - 1) : '0;
          end
        end

        S_UP: begin
          if (|hit) begin
            power_d = '0;
            fault_d = fault_q | hit;
            retry_d = RT_W'(RETRY);
            state_d = S_FAULT;
          end else begin
            power_d = power_q & present;
            if ((power_q & present) == '0) begin
              state_d = S_DETECT;
            end
          end
        end

        S_FAULT: begin
          power_d = '0;
          // Saturating countdown; the cycle that reaches zero leaves FAULT.
          if (retry_q <= RT_W'(1)) begin
            retry_d = '0;
            state_d = S_DETECT;
          end else begin
            retry_d = retry_q - RT_W'(1);
          end
        end

        default: begin
          power_d = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      power_q <= '0;
      route_q <= '0;
      fault_q <= '0;
      mask_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      power_q <= power_d;
      route_q <= route_d;
      fault_q <= fault_d;
      mask_q  <= mask_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      retry_q <= retry_d;
    end
  end

  assign pair_power_on_o  = power_q;
  assign pair_route_sel_o = route_q;
  assign fault_latched_o  = fault_q;
  assign link_up_o        = (state_q == S_UP);
  assign state_o          = state_q;

endmodule

// File: tb/tb_link_power_pair_sequencer.sv
// Directed, table-driven bench for link_power_pair_sequencer (default
// parameters). Each row applies inputs, advances a fixed number of clock
// edges and compares every output against hand-computed values.
module tb_link_power_pair_sequencer;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       swap_mode;
  logic [3:0] pair_sense;
  logic [3:0] pair_fault;
  logic [3:0] pair_power_on;
  logic [3:0] pair_route_sel;
  logic [3:0] fault_latched;
  logic       link_up;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  link_power_pair_sequencer #(
    .PAIRS(4), .DEBOUNCE(16), .STAGGER(64), .RETRY(1024)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .enable_i         (enable),
    .swap_mode_i      (swap_mode),
    .pair_sense_i     (pair_sense),
    .pair_fault_i     (pair_fault),
    .pair_power_on_o  (pair_power_on),
    .pair_route_sel_o (pair_route_sel),
    .fault_latched_o  (fault_latched),
    .link_up_o        (link_up),
    .state_o          (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       en;
    logic       swap;
    logic [3:0] sense;
    logic [3:0] flt;
    int         n;
    logic [2:0] st;
    logic [3:0] pw;
    logic [3:0] rt;
    logic [3:0] fl;
    logic       lk;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic en, logic swap, logic [3:0] sense,
                              logic [3:0] flt, int n, logic [2:0] st, logic [3:0] pw,
                              logic [3:0] rt, logic [3:0] fl, logic lk);
    vec_t v;
    v.name = name; v.en = en; v.swap = swap; v.sense = sense; v.flt = flt; v.n = n;
    v.st = st; v.pw = pw; v.rt = rt; v.fl = fl; v.lk = lk;
    return v;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic [2:0] st, input logic [3:0] pw,
                           input logic [3:0] rt, input logic [3:0] fl, input logic lk);
    check({nm, ".state"}, {5'd0, state}, {5'd0, st});
    check({nm, ".power"}, {4'd0, pair_power_on}, {4'd0, pw});
    check({nm, ".route"}, {4'd0, pair_route_sel}, {4'd0, rt});
    check({nm, ".fault"}, {4'd0, fault_latched}, {4'd0, fl});
    check({nm, ".link"}, {7'd0, link_up}, {7'd0, lk});
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Watchdog: the whole run is a few thousand cycles.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Cumulative edge counts in comments are relative to the row start.
    vecs.push_back(mk("detect_wait",      1, 0, 4'hF, 4'h0,   18, 1, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk("ramp_entry",       1, 0, 4'hF, 4'h0,    1, 2, 4'h1, 4'h0, 4'h0, 0));
    vecs.push_back(mk("step0_dwell",      1, 0, 4'hF, 4'h0,   63, 2, 4'h1, 4'h0, 4'h0, 0));
    vecs.push_back(mk("step1_on",         1, 0, 4'hF, 4'h0,    1, 2, 4'h3, 4'h0, 4'h0, 0));
    vecs.push_back(mk("step3_on",         1, 0, 4'hF, 4'h0,  128, 2, 4'hF, 4'h0, 4'h0, 0));
    vecs.push_back(mk("ramp_end",         1, 0, 4'hF, 4'h0,   63, 2, 4'hF, 4'h0, 4'h0, 0));
    vecs.push_back(mk("link_up",          1, 0, 4'hF, 4'h0,    1, 3, 4'hF, 4'h0, 4'h0, 1));
    vecs.push_back(mk("fault_p2",         1, 0, 4'hF, 4'h4,    1, 4, 4'h0, 4'h0, 4'h4, 0));
    vecs.push_back(mk("retry_hold",       1, 0, 4'hF, 4'h0, 1023, 4, 4'h0, 4'h0, 4'h4, 0));
    vecs.push_back(mk("retry_done",       1, 0, 4'hF, 4'h0,    1, 1, 4'h0, 4'h0, 4'h4, 0));
    vecs.push_back(mk("reramp",           1, 0, 4'hF, 4'h0,    1, 2, 4'h1, 4'h0, 4'h0, 0));
    vecs.push_back(mk("reramp_end",       1, 0, 4'hF, 4'h0,  255, 2, 4'hF, 4'h0, 4'h0, 0));
    vecs.push_back(mk("relink",           1, 0, 4'hF, 4'h0,    1, 3, 4'hF, 4'h0, 4'h0, 1));
    vecs.push_back(mk("glitch15",         1, 0, 4'hB, 4'h0,   15, 3, 4'hF, 4'h0, 4'h0, 1));
    vecs.push_back(mk("restore",          1, 0, 4'hF, 4'h0,   20, 3, 4'hF, 4'h0, 4'h0, 1));
    vecs.push_back(mk("drop_wait",        1, 0, 4'hB, 4'h0,   18, 3, 4'hF, 4'h0, 4'h0, 1));
    vecs.push_back(mk("drop_p2",          1, 0, 4'hB, 4'h0,    1, 3, 4'hB, 4'h0, 4'h0, 1));
    vecs.push_back(mk("all_low_wait",     1, 0, 4'h0, 4'h0,   18, 3, 4'hB, 4'h0, 4'h0, 1));
    vecs.push_back(mk("all_low",          1, 0, 4'h0, 4'h0,    1, 1, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk("swap_detect",      1, 1, 4'h5, 4'h0,   18, 1, 4'h0, 4'h0, 4'h0, 0));
    vecs.push_back(mk("swap_entry",       1, 1, 4'h5, 4'h0,    1, 2, 4'h1, 4'hF, 4'h0, 0));
    vecs.push_back(mk("swap_step0",       1, 1, 4'h5, 4'h0,   64, 2, 4'h1, 4'hF, 4'h0, 0));
    vecs.push_back(mk("swap_step2",       1, 1, 4'h5, 4'h0,    1, 2, 4'h5, 4'hF, 4'h0, 0));
    vecs.push_back(mk("swap_step2_dwell", 1, 1, 4'h5, 4'h0,   64, 2, 4'h5, 4'hF, 4'h0, 0));
    vecs.push_back(mk("swap_up",          1, 1, 4'h5, 4'h0,    1, 3, 4'h5, 4'hF, 4'h0, 1));
    vecs.push_back(mk("swap_ignored",     1, 0, 4'h5, 4'h0,    5, 3, 4'h5, 4'hF, 4'h0, 1));
    vecs.push_back(mk("disable_up",       0, 0, 4'h5, 4'h0,    1, 0, 4'h0, 4'hF, 4'h0, 0));
    vecs.push_back(mk("reenable",         1, 0, 4'h5, 4'h0,    1, 1, 4'h0, 4'hF, 4'h0, 0));
    vecs.push_back(mk("ramp_again",       1, 0, 4'h5, 4'h0,    1, 2, 4'h1, 4'h0, 4'h0, 0));
    vecs.push_back(mk("fault_ramp",       1, 0, 4'h5, 4'h1,    1, 4, 4'h0, 4'h0, 4'h1, 0));
    vecs.push_back(mk("disable_fault",    0, 0, 4'h5, 4'h0,    1, 0, 4'h0, 4'h0, 4'h1, 0));
    vecs.push_back(mk("detect3",          1, 1, 4'h5, 4'h0,    1, 1, 4'h0, 4'h0, 4'h1, 0));
    vecs.push_back(mk("ramp3",            1, 1, 4'h5, 4'h0,    1, 2, 4'h1, 4'hF, 4'h0, 0));
    vecs.push_back(mk("disable_vs_fault", 0, 1, 4'h5, 4'h1,    1, 0, 4'h0, 4'hF, 4'h0, 0));
    vecs.push_back(mk("ramp4",            1, 1, 4'h5, 4'h0,    2, 2, 4'h1, 4'hF, 4'h0, 0));

    // Reset state, asserted from time 0.
    rst_n      = 1'b0;
    enable     = 1'b1;
    swap_mode  = 1'b0;
    pair_sense = 4'hF;
    pair_fault = 4'h0;
    #3;
    check_all("reset_t0", 0, 4'h0, 4'h0, 4'h0, 0);
    @(posedge clk);
    @(posedge clk);
    #4;
    check_all("reset_held", 0, 4'h0, 4'h0, 4'h0, 0);
    rst_n = 1'b1;

    for (int r = 0; r < vecs.size(); r++) begin
      enable     = vecs[r].en;
      swap_mode  = vecs[r].swap;
      pair_sense = vecs[r].sense;
      pair_fault = vecs[r].flt;
      step(vecs[r].n);
      $display("row %0d %s: state=%0d power=%b route=%b fault=%b link=%b",
               r, vecs[r].name, state, pair_power_on, pair_route_sel, fault_latched, link_up);
      check_all(vecs[r].name, vecs[r].st, vecs[r].pw, vecs[r].rt, vecs[r].fl, vecs[r].lk);
    end

    // Reset pulse mid-RAMP: outputs clear without waiting for a clock edge.
    pair_fault = 4'h0;
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset mid-ramp: state=%0d power=%b route=%b fault=%b link=%b",
             state, pair_power_on, pair_route_sel, fault_latched, link_up);
    check_all("async_reset", 0, 4'h0, 4'h0, 4'h0, 0);
    @(posedge clk);
    @(posedge clk);
    #4;
    rst_n = 1'b1;

    // Restart from IDLE: a full debounce window must elapse before power.
    step(18);
    $display("post-reset debounce: state=%0d power=%b", state, pair_power_on);
    check("post_reset_wait.state", {5'd0, state}, 8'd1);
    check("post_reset_wait.power", {4'd0, pair_power_on}, 8'h00);
    step(1);
    $display("post-reset ramp: state=%0d power=%b route=%b", state, pair_power_on, pair_route_sel);
    check("post_reset_ramp.state", {5'd0, state}, 8'd2);
    check("post_reset_ramp.power", {4'd0, pair_power_on}, 8'h01);
    check("post_reset_ramp.route", {4'd0, pair_route_sel}, 8'h0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
